des_tx_serializer: RTL and testbench
====================================

Name: des_tx_serializer

Overview:
- Downstream neighbour of the encryptor core.
- Consumes each 64-bit processed block (trans_data / trans_data_ready) and returns the handshake_ack that releases the core's controller.
- Streams each block as 8 bytes over a valid/ready byte interface into the USB transmit FIFO.
- Double-buffered: one block is held while the previous one is still being shifted out, so the core never stalls on back-to-back blocks.

Parameters:
- LSB_FIRST, 1, 1: byte 0 = trans_data[7:0] is sent first; 0: trans_data[63:56] is sent first.
- CNT_W, 16, width of the sent-block counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- trans_data  input  64  processed block from the encryptor core.
- trans_data_ready  input  1  level; high while the core presents a valid block.
- handshake_ack  output  1  one-cycle pulse; block captured.
- tx_byte  output  8  current byte to the FIFO.
- tx_valid  output  1  tx_byte is valid.
- tx_ready  input  1  FIFO accepts tx_byte this cycle.
- tx_busy  output  1  hold buffer full or shifter active.
- block_count  output  CNT_W  number of blocks fully sent; wraps.

Behaviour:
- Reset: rst sampled on the rising clk edge.
  - All outputs go to 0: handshake_ack, tx_valid, tx_byte, tx_busy, block_count.
  - hold_full=0, armed=1, state=IDLE, byte_idx=0.
- Capture condition, evaluated on register values at the start of the cycle: trans_data_ready & armed & ~hold_full.
  - hold_reg <= trans_data; hold_full <= 1; armed <= 0.
  - handshake_ack=1 in the next cycle only, exactly one cycle.
- Re-arm: armed <= 1 on any cycle where trans_data_ready=0.
  - A level that stays high after ack is never captured twice.
- When hold_full=1 and trans_data_ready is high, no ack is issued; the core waits, which is legal.
- State IDLE, with hold_full=1:
  - shift_reg <= hold_reg; hold_full <= 0; byte_idx <= 0; go to SEND.
  - tx_valid rises in the cycle after the transfer.
- State SEND:
  - tx_valid=1; tx_byte = byte byte_idx of shift_reg, ordered per LSB_FIRST.
  - tx_byte stays stable while tx_valid & ~tx_ready.
  - On tx_valid & tx_ready: byte_idx increments.
  - On acceptance with byte_idx=7: block_count increments, wrapping from all-ones to 0.
    - If hold_full=1: reload shift_reg from hold_reg in the same edge and stay in SEND. No bubble; the next byte 0 is valid the following cycle.
    - Otherwise: return to IDLE.
- A capture and a hold-to-shift transfer can occur in the same edge only when hold_full was 0 at the start of the cycle. In that case only the capture happens, and the transfer follows one cycle later.
- tx_busy = hold_full | (state != IDLE).
- Minimum latency: trans_data_ready high at cycle N.
  - Capture at edge N; ack high in cycle N+1.
  - Transfer at edge N+1; first tx_valid in cycle N+2.
- tx_ready held low indefinitely: no state changes except capture into a free hold buffer.
- Reset mid-block: the block in progress and any held block are discarded, no ack is issued, and block_count clears.

Optional Feature:
- Macro: SER_CHECKSUM_EN.
- Defined:
  - Adds state CHK after byte 7.
  - Sends a 9th byte equal to the XOR of the 8 data bytes, accumulated as bytes are accepted.
  - block_count increments and the reload-or-IDLE decision is made on CHK acceptance instead of byte 7.
  - The checksum accumulator clears on every shift_reg load.
- Undefined: exactly 8 bytes per block; no CHK state or accumulator logic is present.

Test Plan:
- Reset then single block (LSB_FIRST=1, tx_ready=1): trans_data=64'h0807060504030201, trans_data_ready held high.
  - ack is one pulse in cycle N+1.
  - Bytes 01..08 on consecutive cycles starting N+2.
  - block_count=1; tx_busy low after the last byte.
- LSB_FIRST=0, same block: bytes 08,07,…,01 in that order.
- Back-to-back: second block 64'hFFEEDDCCBBAA9988 presented while the first is shifting (trans_data_ready toggled low then high).
  - Second ack arrives during the first block.
  - Byte 88 follows byte 08 with no idle cycle; block_count=2.
- Backpressure: tx_ready low for 5 cycles at byte_idx=3, plus a third block offered while hold is full.
  - tx_byte stays at 04 and stable.
  - No ack for the third block until the hold buffer drains.
- Level hold: trans_data_ready held high for 20 cycles with one block → exactly one ack and one 8-byte burst.
- Reset at byte_idx=5 with a block held: next cycle tx_valid=0, tx_busy=0, block_count=0, no ack.
- With SER_CHECKSUM_EN, block 0x0807060504030201: 9th byte = 0x08.

Source files
------------

// File: rtl/des_tx_serializer.sv
// Double-buffered 64-bit block to byte-stream serializer sitting between the
// encryptor core and the USB transmit FIFO. Optional checksum byte: SER_CHECKSUM_EN.
module des_tx_serializer #(
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      trans_data,
  input  logic             trans_data_ready,
  output logic             handshake_ack,
  output logic [7:0]       tx_byte,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_busy,
  output logic [CNT_W-1:0] block_count
);

`ifdef SER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t      state, state_nxt;
  logic [63:0] hold_reg, shift_reg;
  logic        hold_full, armed;
  logic [2:0]  byte_idx;
  logic [2:0]  sel_idx;
  logic        capture, accept, last_accept, load_shift;
`ifdef SER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // The hold buffer is only ever written when it is empty, so a capture and a
  // hold-to-shift transfer can never collide on the same edge.
  assign capture = trans_data_ready & armed & ~hold_full;
  assign accept  = tx_valid & tx_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    last_accept = 1'b0;
`ifdef SER_CHECKSUM_EN
    last_accept = accept & (state == CHK);
`else
    last_accept = accept & (state == SEND) & (byte_idx == 3'd7);
`endif
  end

  assign load_shift = hold_full & (((state == IDLE)) | last_accept);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (hold_full) state_nxt = SEND;
      SEND: begin
        if (accept && byte_idx == 3'd7) begin
`ifdef SER_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = hold_full ? SEND : IDLE;
`endif
        end
      end
`ifdef SER_CHECKSUM_EN
      CHK: if (accept) state_nxt = hold_full ? SEND : IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers are reset; the 64-bit data buffers are not, since they
  // are only observed after a load guarded by hold_full / state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full     <= 1'b0;
      armed         <= 1'b1;
      byte_idx      <= 3'd0;
      block_count   <= '0;
      handshake_ack <= 1'b0;
    end else begin
      handshake_ack <= capture;
      if (capture)                armed <= 1'b0;
      else if (!trans_data_ready) armed <= 1'b1;

      if (capture)         hold_full <= 1'b1;
      else if (load_shift) hold_full <= 1'b0;

      if (load_shift)                    byte_idx <= 3'd0;
      else if (accept && state == SEND)  byte_idx <= byte_idx + 3'd1;

      if (last_accept) block_count <= block_count + CNT_W'(1);
    end
  end

  // NOTE: wide data registers carry no reset; their contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    if (capture)    hold_reg  <= trans_data;
    if (load_shift) shift_reg <= hold_reg;
  end

`ifdef SER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)                          csum <= 8'h00;
    else if (load_shift)              csum <= 8'h00;
    else if (accept && state == SEND) csum <= csum ^ tx_byte;
  end
`endif

  assign sel_idx = (LSB_FIRST != 0) ? byte_idx : (3'd7 - byte_idx);

  // Output logic
  always_comb begin
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    case (state)
      SEND: begin
        tx_valid = 1'b1;
        tx_byte  = shift_reg[{sel_idx, 3'b000} +: 8];
      end
`ifdef SER_CHECKSUM_EN
      CHK: begin
        tx_valid = 1'b1;
        tx_byte  = csum;
      end
`endif
      default: ;
    endcase
    tx_busy = hold_full | (state != IDLE);
  end

endmodule

// File: tb/tb_des_tx_serializer.sv
// Directed self-checking bench for des_tx_serializer; two instances cover both
// byte orders from the same stimulus. Honours SER_CHECKSUM_EN when defined.
module tb_des_tx_serializer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [63:0]      trans_data;
  logic             trans_data_ready;
  logic             tx_ready;
  logic             handshake_ack, tx_valid, tx_busy;
  logic [7:0]       tx_byte;
  logic [CNT_W-1:0] block_count;
  logic             m_ack, m_valid, m_busy;
  logic [7:0]       m_byte;
  logic [CNT_W-1:0] m_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  des_tx_serializer #(.LSB_FIRST(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .trans_data(trans_data), .trans_data_ready(trans_data_ready),
    .handshake_ack(handshake_ack), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .block_count(block_count));

  des_tx_serializer #(.LSB_FIRST(0), .CNT_W(CNT_W)) dut_msb (
    .clk(clk), .rst(rst), .trans_data(trans_data), .trans_data_ready(trans_data_ready),
    .handshake_ack(m_ack), .tx_byte(m_byte), .tx_valid(m_valid),
    .tx_ready(tx_ready), .tx_busy(m_busy), .block_count(m_count));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; trans_data_ready = 1'b0; tx_ready = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  int acks, valids;
  logic [7:0] exp_b;

  initial begin
    trans_data = 64'h0;
    do_reset();
    rst = 1'b1;
    step();
    check("rst_ack",   {63'd0, handshake_ack}, 64'd0);
    check("rst_valid", {63'd0, tx_valid},      64'd0);
    check("rst_byte",  {56'd0, tx_byte},       64'd0);
    check("rst_busy",  {63'd0, tx_busy},       64'd0);
    check("rst_count", {48'd0, block_count},   64'd0);
    rst = 1'b0;

    // Single block, level held high throughout.
    trans_data = 64'h0807060504030201; trans_data_ready = 1'b1;
    step();
    check("single_ack",      {63'd0, handshake_ack}, 64'd1);
    check("single_pre_valid", {63'd0, tx_valid},     64'd0);
    check("single_busy",     {63'd0, tx_busy},       64'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      exp_b = 8'(i + 1);
      check("single_valid", {63'd0, tx_valid}, 64'd1);
      check("single_byte",  {56'd0, tx_byte},  {56'd0, exp_b});
      exp_b = 8'(8 - i);
      check("msb_byte",     {56'd0, m_byte},   {56'd0, exp_b});
      check("single_noack", {63'd0, handshake_ack}, 64'd0);
    end
`ifdef SER_CHECKSUM_EN
    step();
    check("chk_byte",     {56'd0, tx_byte}, 64'h08);
    check("chk_msb_byte", {56'd0, m_byte},  64'h08);
`endif
    step();
    check("single_idle",  {63'd0, tx_valid},  64'd0);
    check("single_nbusy", {63'd0, tx_busy},   64'd0);
    check("single_count", {48'd0, block_count}, 64'd1);
    check("msb_count",    {48'd0, m_count},   64'd1);
    trans_data_ready = 1'b0;

    // Back-to-back blocks: second one captured while the first shifts out.
    do_reset();
    trans_data = 64'h0807060504030201; trans_data_ready = 1'b1;
    step();
    check("b2b_ack1", {63'd0, handshake_ack}, 64'd1);
    trans_data_ready = 1'b0;
    step();
    check("b2b_byte01", {56'd0, tx_byte}, 64'h01);
    trans_data = 64'hFFEEDDCCBBAA9988; trans_data_ready = 1'b1;
    step();
    check("b2b_ack2",   {63'd0, handshake_ack}, 64'd1);
    check("b2b_byte02", {56'd0, tx_byte}, 64'h02);
    trans_data_ready = 1'b0;
    for (int i = 3; i <= 8; i++) step();
    check("b2b_byte08", {56'd0, tx_byte}, 64'h08);
`ifdef SER_CHECKSUM_EN
    step();
    check("b2b_chk1", {56'd0, tx_byte}, 64'h08);
`endif
    step();
    check("b2b_nobubble", {63'd0, tx_valid}, 64'd1);
    check("b2b_byte88",   {56'd0, tx_byte},  64'h88);
    check("b2b_count1",   {48'd0, block_count}, 64'd1);
    for (int i = 1; i < 8; i++) step();
    check("b2b_byteFF", {56'd0, tx_byte}, 64'hFF);
`ifdef SER_CHECKSUM_EN
    step();
    check("b2b_chk2", {56'd0, tx_byte}, 64'h00);
`endif
    step();
    check("b2b_idle",   {63'd0, tx_valid},    64'd0);
    check("b2b_count2", {48'd0, block_count}, 64'd2);

    // Backpressure at byte_idx=3 with a third block offered while hold is full.
    do_reset();
    trans_data = 64'h0807060504030201; trans_data_ready = 1'b1;
    step();
    trans_data_ready = 1'b0;
    step();
    trans_data = 64'hFFEEDDCCBBAA9988; trans_data_ready = 1'b1;
    step();
    check("bp_ack2", {63'd0, handshake_ack}, 64'd1);
    trans_data_ready = 1'b0;
    step();
    check("bp_byte03", {56'd0, tx_byte}, 64'h03);
    trans_data = 64'h1716151413121110; trans_data_ready = 1'b1;
    step();
    check("bp_byte04", {56'd0, tx_byte}, 64'h04);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_stall_byte",  {56'd0, tx_byte},       64'h04);
      check("bp_stall_valid", {63'd0, tx_valid},      64'd1);
      check("bp_stall_noack", {63'd0, handshake_ack}, 64'd0);
    end
    tx_ready = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      step();
      exp_b = 8'(i);
      check("bp_resume_byte", {56'd0, tx_byte}, {56'd0, exp_b});
      check("bp_hold_noack",  {63'd0, handshake_ack}, 64'd0);
    end
`ifdef SER_CHECKSUM_EN
    step();
    check("bp_chk_noack", {63'd0, handshake_ack}, 64'd0);
`endif
    step();
    check("bp_byte88",  {56'd0, tx_byte}, 64'h88);
    check("bp_noack88", {63'd0, handshake_ack}, 64'd0);
    step();
    check("bp_ack3",   {63'd0, handshake_ack}, 64'd1);
    check("bp_byte99", {56'd0, tx_byte}, 64'h99);
    trans_data_ready = 1'b0;

    // Level held high for 20 cycles: one ack, one burst.
    do_reset();
    trans_data = 64'h0807060504030201; trans_data_ready = 1'b1;
    acks = 0; valids = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      acks   += int'(handshake_ack);
      valids += int'(tx_valid);
    end
`ifdef SER_CHECKSUM_EN
    check("level_valids", 64'(valids), 64'd9);
`else
    check("level_valids", 64'(valids), 64'd8);
`endif
    check("level_acks",  64'(acks), 64'd1);
    check("level_count", {48'd0, block_count}, 64'd1);
    trans_data_ready = 1'b0;

    // Reset at byte_idx=5 with a second block held.
    do_reset();
    trans_data = 64'h0807060504030201; trans_data_ready = 1'b1;
    step();
    trans_data_ready = 1'b0;
    step();
    trans_data = 64'hFFEEDDCCBBAA9988; trans_data_ready = 1'b1;
    step();
    trans_data_ready = 1'b0;
    for (int i = 3; i <= 6; i++) step();
    check("mid_byte06", {56'd0, tx_byte}, 64'h06);
    check("mid_busy",   {63'd0, tx_busy}, 64'd1);
    rst = 1'b1;
    step();
    check("mid_valid", {63'd0, tx_valid},      64'd0);
    check("mid_busy0", {63'd0, tx_busy},       64'd0);
    check("mid_count", {48'd0, block_count},   64'd0);
    check("mid_ack",   {63'd0, handshake_ack}, 64'd0);
    rst = 1'b0;
    step(); step();
    check("mid_post_valid", {63'd0, tx_valid},      64'd0);
    check("mid_post_ack",   {63'd0, handshake_ack}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
